// File: rtl/signed_bcd_fmt.sv
// Signed 16-bit to four-digit 7-seg code formatter using a serial double-dabble core.
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module signed_bcd_fmt (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [15:0] iValue,
    input  logic        iStart,
    output logic        oBusy,
    output logic        oDone,
    output logic        oOvf,
    output logic [3:0]  oDigit3,
    output logic [3:0]  oDigit2,
    output logic [3:0]  oDigit1,
    output logic [3:0]  oDigit0
);

    localparam int unsigned VAL_W = 16;
    localparam int unsigned EXT_W = VAL_W + 1;
    localparam int unsigned MAG_W = 14;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned N_DIG = 4;
    localparam int unsigned BCD_W = DIG_W * N_DIG;
    localparam int unsigned SR_W  = BCD_W + MAG_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(MAG_W - 1);
    localparam logic [EXT_W-1:0] MAG_MAX    = EXT_W'((1 << MAG_W) - 1);
    localparam logic [EXT_W-1:0] POS_LIMIT  = EXT_W'(9999);
    localparam logic [EXT_W-1:0] NEG_LIMIT  = EXT_W'(999);
    localparam logic [DIG_W-1:0] CODE_BLANK = DIG_W'(4'hA);
    localparam logic [DIG_W-1:0] CODE_DASH  = DIG_W'(4'hB);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORMAT
    } state_t;

    state_t                        state_q, state_d;
    logic [SR_W-1:0]               sr_q, sr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          neg_q, neg_d;
    logic                          rng_ovf_q, rng_ovf_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          ovf_q, ovf_d;
    logic [N_DIG-1:0][DIG_W-1:0]   dig_q, dig_d;

    logic [EXT_W-1:0]              abs_c;
    logic [MAG_W-1:0]              mag_c;
    logic                          in_ovf_c;
    logic [BCD_W-1:0]              bcd_c;
    logic [N_DIG-1:0][DIG_W-1:0]   fmt_c;

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int k = 0; k < int'(N_DIG); k++) begin
            if (t[MAG_W + DIG_W*k +: DIG_W] >= DIG_W'(5))
                t[MAG_W + DIG_W*k +: DIG_W] = t[MAG_W + DIG_W*k +: DIG_W] + DIG_W'(3);
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // Magnitude is computed 17 bits wide so -32768 does not wrap.
    always_comb begin
        abs_c    = iValue[VAL_W-1] ? (EXT_W'(0) - {1'b1, iValue}) : {1'b0, iValue};
        mag_c    = (abs_c > MAG_MAX) ? '1 : abs_c[MAG_W-1:0];
        in_ovf_c = iValue[VAL_W-1] ? (abs_c > NEG_LIMIT) : (abs_c > POS_LIMIT);
    end

    assign bcd_c = sr_q[MAG_W +: BCD_W];

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
`endif
        for (int i = 0; i < int'(N_DIG); i++)
            fmt_c[i] = bcd_c[DIG_W*i +: DIG_W];
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = int'(N_DIG) - 1; i >= 1; i--) begin
            if (lead && (fmt_c[i] == '0))
                fmt_c[i] = CODE_BLANK;
            else
                lead = 1'b0;
        end
        // The minus sign takes the blank slot just left of the leading digit.
        if (neg_q) begin
            for (int i = int'(N_DIG) - 1; i >= 1; i--) begin
                if ((fmt_c[i] == CODE_BLANK) && (fmt_c[i-1] != CODE_BLANK))
                    fmt_c[i] = CODE_DASH;
            end
        end
`else
        if (neg_q)
            fmt_c[N_DIG-1] = CODE_DASH;
`endif
        if (rng_ovf_q)
            fmt_c = {N_DIG{CODE_DASH}};
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rng_ovf_d = rng_ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        dig_d     = dig_q;
        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d   = SHIFT;
                    sr_d      = {BCD_W'(0), mag_c};
                    cnt_d     = '0;
                    neg_d     = iValue[VAL_W-1];
                    rng_ovf_d = in_ovf_c;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                sr_d  = dd_step(sr_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT)
                    state_d = FORMAT;
            end
            FORMAT: begin
                dig_d   = fmt_c;
                ovf_d   = rng_ovf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rng_ovf_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dig_q     <= {N_DIG{CODE_BLANK}};
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rng_ovf_q <= rng_ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            dig_q     <= dig_d;
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oOvf    = ovf_q;
    assign oDigit3 = dig_q[3];
    assign oDigit2 = dig_q[2];
    assign oDigit1 = dig_q[1];
    assign oDigit0 = dig_q[0];

endmodule

// File: tb/tb_signed_bcd_fmt.sv
// Directed self-checking bench for signed_bcd_fmt; expectations follow LEADING_ZERO_BLANK_EN.
module tb_signed_bcd_fmt;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        start;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  d3, d2, d1, d0;

    int errors = 0;
    int checks = 0;

    signed_bcd_fmt dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iValue  (value),
        .iStart  (start),
        .oBusy   (busy),
        .oDone   (done),
        .oOvf    (ovf),
        .oDigit3 (d3),
        .oDigit2 (d2),
        .oDigit1 (d1),
        .oDigit0 (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digits();
        return {d3, d2, d1, d0};
    endfunction

    // Stimulus only: pulse start with v, then wait (bounded) for oDone; lat = cycles after accept edge.
    task automatic do_convert(input logic [15:0] v, output int lat);
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; value = 16'd0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, ovf});
        end
        checks++;
        if (digits() !== 16'hAAAA) begin
            errors++; $display("FAIL reset_digits: got %h expected aaaa", digits());
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] held;
        value = 16'd1234; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_accept: got %b expected 1", busy);
        end
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        checks++;
        if (lat !== 15) begin
            errors++; $display("FAIL latency_1234: got %0d expected 15", lat);
        end
        checks++;
        if (digits() !== 16'h1234 || ovf !== 1'b0) begin
            errors++; $display("FAIL value_1234: got %h ovf=%b expected 1234 ovf=0", digits(), ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_during_done: got %b expected 0", busy);
        end
        held = digits();
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_single_cycle: got %b expected 0", done);
        end
        value = 16'd7777;
        repeat (5) tick();
        checks++;
        if (digits() !== 16'h1234 || done !== 1'b0) begin
            errors++; $display("FAIL hold_between_done: got %h done=%b expected 1234 done=0", digits(), done);
        end
    endtask

    task automatic test_negative_zero();
        int lat;
        do_convert(16'hFFD6, lat);  // -42
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (lat !== 15 || digits() !== 16'hAB42 || ovf !== 1'b0) begin
            errors++; $display("FAIL value_m42: got %h lat=%0d ovf=%b expected ab42 lat=15 ovf=0", digits(), lat, ovf);
        end
`else
        if (lat !== 15 || digits() !== 16'hB042 || ovf !== 1'b0) begin
            errors++; $display("FAIL value_m42: got %h lat=%0d ovf=%b expected b042 lat=15 ovf=0", digits(), lat, ovf);
        end
`endif
        tick();
        do_convert(16'd0, lat);
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (lat !== 15 || digits() !== 16'hAAA0) begin
            errors++; $display("FAIL value_zero: got %h lat=%0d expected aaa0", digits(), lat);
        end
`else
        if (lat !== 15 || digits() !== 16'h0000) begin
            errors++; $display("FAIL value_zero: got %h lat=%0d expected 0000", digits(), lat);
        end
`endif
        tick();
        do_convert(16'hFC19, lat);  // -999, lowest in range
        checks++;
        if (lat !== 15 || digits() !== 16'hB999 || ovf !== 1'b0) begin
            errors++; $display("FAIL value_m999: got %h ovf=%b expected b999 ovf=0", digits(), ovf);
        end
        tick();
    endtask

    task automatic test_range();
        logic [15:0] vals [4];
        logic [15:0] exp_d [4];
        logic        exp_o [4];
        int lat;
        vals[0] = 16'd10000; exp_d[0] = 16'hBBBB; exp_o[0] = 1'b1;
        vals[1] = 16'hFC18;  exp_d[1] = 16'hBBBB; exp_o[1] = 1'b1;  // -1000
        vals[2] = 16'h8000;  exp_d[2] = 16'hBBBB; exp_o[2] = 1'b1;  // -32768
        vals[3] = 16'd9999;  exp_d[3] = 16'h9999; exp_o[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_convert(vals[i], lat);
            checks++;
            if (lat !== 15 || digits() !== exp_d[i] || ovf !== exp_o[i]) begin
                errors++;
                $display("FAIL range_%0d: got %h ovf=%b lat=%0d expected %h ovf=%b lat=15",
                         i, digits(), ovf, lat, exp_d[i], exp_o[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        int extra;
        value = 16'd321; start = 1'b1;
        tick();
        start = 1'b0;
        value = 16'd7777;
        repeat (3) tick();
        start = 1'b1; value = 16'd8888;
        tick();
        start = 1'b0;
        lat = 4;
        while (!done && lat < 40) begin tick(); lat++; end
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (lat !== 15 || digits() !== 16'hA321) begin
            errors++; $display("FAIL sampled_value: got %h lat=%0d expected a321 lat=15", digits(), lat);
        end
`else
        if (lat !== 15 || digits() !== 16'h0321) begin
            errors++; $display("FAIL sampled_value: got %h lat=%0d expected 0321 lat=15", digits(), lat);
        end
`endif
        extra = 0;
        repeat (20) begin
            tick();
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL no_queuing: got %0d busy/done cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        value = 16'd56; start = 1'b1;
        tick();
        value = 16'd78;
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (lat !== 15 || digits() !== 16'hAA56) begin
            errors++; $display("FAIL b2b_first: got %h lat=%0d expected aa56 lat=15", digits(), lat);
        end
`else
        if (lat !== 15 || digits() !== 16'h0056) begin
            errors++; $display("FAIL b2b_first: got %h lat=%0d expected 0056 lat=15", digits(), lat);
        end
`endif
        gap = 0;
        tick(); gap++;
        while (!done && gap < 40) begin tick(); gap++; end
        start = 1'b0;
        checks++;
        if (gap !== 16) begin
            errors++; $display("FAIL b2b_period: got %0d expected 16", gap);
        end
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (digits() !== 16'hAA78) begin
            errors++; $display("FAIL b2b_second: got %h expected aa78", digits());
        end
`else
        if (digits() !== 16'h0078) begin
            errors++; $display("FAIL b2b_second: got %h expected 0078", digits());
        end
`endif
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        do_convert(16'd10000, lat);
        tick();
        value = 16'd1234; start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        repeat (6) tick();           // through E6
        rst = 1'b1;
        tick();                      // E7
        rst = 1'b0;
        checks++;
        if ({busy, done, ovf} !== 3'b000 || digits() !== 16'hAAAA) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b ovf=%b %h expected 0 0 0 aaaa",
                               busy, done, ovf, digits());
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", seen);
        end
        rst = 1'b1; start = 1'b1; value = 16'd77;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_dominates_start: got busy=%b expected 0", busy);
        end
        do_convert(16'd5, lat);
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (lat !== 15 || digits() !== 16'hAAA5) begin
            errors++; $display("FAIL after_reset_5: got %h lat=%0d expected aaa5 lat=15", digits(), lat);
        end
`else
        if (lat !== 15 || digits() !== 16'h0005) begin
            errors++; $display("FAIL after_reset_5: got %h lat=%0d expected 0005 lat=15", digits(), lat);
        end
`endif
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; value = 16'd0;
        test_reset();
        test_basic();
        test_negative_zero();
        test_range();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_bcd_fmt.md
SIGNED_BCD_FMT -- requirements
Module: signed_bcd_fmt

Interface
REQ-001 SHALL have port iCLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port iRST, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port iValue, input, 16, signed two's-complement value to display.
REQ-004 SHALL have port iStart, input, 1, conversion request.
REQ-005 SHALL have port oBusy, output, 1, conversion in progress.
REQ-006 SHALL have port oDone, output, 1, one-cycle completion pulse.
REQ-007 SHALL have port oOvf, output, 1, last accepted value out of displayable range.
REQ-008 SHALL have ports oDigit3..oDigit0, output, 4 each, per-digit codes for the downstream 7-seg decoders; oDigit3 is leftmost.
- Codes: 0-9 decimal digit, 4'hA blank, 4'hB minus/dash.

Function
REQ-009 SHALL use FSM states IDLE, SHIFT, FORMAT.
- IDLE -> SHIFT: iStart=1.
- SHIFT -> FORMAT: after 14th shift.
- FORMAT -> IDLE: unconditional.
REQ-010 SHALL accept iStart only in IDLE; iStart while oBusy=1 ignored, no queuing.
REQ-011 SHALL sample iValue at accept edge (E0); later iValue changes SHALL not affect the conversion.
REQ-012 SHALL at E0 latch sign, 14-bit magnitude (|iValue|, saturated), and range flag; clear BCD shift register; zero shift counter.
REQ-013 SHALL perform one double-dabble step per cycle on edges E1..E14.
- Add 3 to each BCD nibble >=5, then shift left one bit.
- After E14, 16-bit BCD holds four digits.
REQ-014 SHALL at E15 (FORMAT) register all oDigit outputs and oOvf, and set oDone=1 for exactly one cycle.
- Latency: 15 cycles from accept edge to outputs/oDone.
REQ-015 SHALL hold oBusy=1 from E0 through E15 exclusive; oBusy=0 while oDone=1.
REQ-016 SHALL accept iStart asserted during the oDone cycle (state IDLE); next result follows 15 cycles later.
REQ-017 SHALL hold oDigit*/oOvf stable between oDone pulses.
REQ-018 SHALL treat displayable range as -999..9999.
- Outside range: all four digits 4'hB, oOvf=1.
- Otherwise oOvf=0.
- -32768 SHALL be handled: out of range, no magnitude wrap.
REQ-019 SHALL, for negative in-range values with LEADING_ZERO_BLANK_EN undefined, place 4'hB in oDigit3 and magnitude in oDigit2..0.
REQ-020 SHALL display zero as digit 0 in oDigit0 in all configurations; no negative zero.

Reset
REQ-021 SHALL, with iRST=1 at a rising edge, force IDLE, oBusy=0, oDone=0, oOvf=0, oDigit3..0=4'hA.
REQ-022 SHALL abort any conversion on reset mid-operation: no oDone pulse, partial result discarded.
REQ-023 SHALL let iRST dominate iStart on the same edge; no conversion accepted.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is defined:
- Replace leading zero digits left of the most significant nonzero digit with 4'hA.
- Never blank oDigit0.
- For negative values, put 4'hB immediately left of the most significant nonzero digit; positions further left 4'hA.
REQ-026 SHALL, when LEADING_ZERO_BLANK_EN is undefined:
- Show all leading zeros as 0.
- Place minus per REQ-019.
- Blanking logic SHALL not be synthesized.

Verification
REQ-027 SHALL cover iValue=1234, iStart pulse -> oDone 15 cycles later; digits 1,2,3,4; oOvf=0.
REQ-028 SHALL cover iValue=-42:
- Macro defined -> A,B,4,2.
- Macro undefined -> B,0,4,2.
REQ-029 SHALL cover iValue=0:
- Macro defined -> A,A,A,0.
- Macro undefined -> 0,0,0,0.
REQ-030 SHALL cover iValue=10000, then -1000, then -32768 -> each B,B,B,B with oOvf=1; then 9999 -> 9,9,9,9, oOvf=0.
REQ-031 SHALL cover back-to-back operation:
- iStart held continuously -> oDone every 16 cycles.
- iValue changed while busy -> result reflects sampled value only.
REQ-032 SHALL cover iRST=1 at E7 of a conversion -> no oDone, oBusy=0, digits A,A,A,A.
- Next iStart with 5 -> 15-cycle latency.
- Result: A,A,A,5 (macro defined) / 0,0,0,5 (undefined).
